// File: rtl/ads_spi_pkg.sv
// ads_spi_pkg: register map, status bit positions, frame constants and FSM encoding for the ADS touch SPI master.
package ads_spi_pkg;
  localparam logic [1:0] A_CMD = 2'd0, A_DATA = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3;
  localparam int ST_BUSY = 0, ST_DONE = 1, ST_OVERRUN = 2, CTRL_IRQ_EN = 0;
  localparam int CMD_BITS = 8;
  localparam logic [4:0] FRAME_CLKS = 5'd24, SAMPLE_FIRST = 5'd10, SAMPLE_LAST = 5'd21;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
endpackage

// File: rtl/ads_spi_frame.sv
// ads_spi_frame: one 24-DCLK conversion frame (command out, 12-bit result in) with dout synchronizer.
module ads_spi_frame
  import ads_spi_pkg::*;
#(
  parameter int CLK_DIV   = 25,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CMD_BITS-1:0]  cmd,
  input  logic                 dout,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] result,
  output logic                 dclk,
  output logic                 cs_n,
  output logic                 din
);
  state_t                state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  phase_q;
  logic [4:0]            bit_q;
  logic [CMD_BITS-1:0]   cmd_sr_q;
  logic [DATA_BITS-1:0]  res_q;
  logic [1:0]            sync_q;
  logic                  tick;
  assign tick   = cnt_q == 8'(CLK_DIV - 1);
  assign busy   = state_q != IDLE;
  assign dclk   = phase_q;
  assign result = res_q;
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:    state_d = start ? SHIFT : IDLE;
      SHIFT:   state_d = (tick && phase_q && bit_q == FRAME_CLKS) ? HOLD : SHIFT;
      HOLD: begin
        state_d = tick ? IDLE : HOLD;
        done    = tick;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      cmd_sr_q <= '0;
      res_q    <= '0;
      sync_q   <= '0;
      cs_n     <= 1'b1;
      din      <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], dout};
      if (state_q == IDLE) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
        if (start) begin
          cs_n     <= 1'b0;
          bit_q    <= 5'd1;
          din      <= cmd[CMD_BITS-1];
          cmd_sr_q <= {cmd[CMD_BITS-2:0], 1'b0};
        end
      end else begin
        cnt_q <= tick ? '0 : cnt_q + 8'd1;
        // End of a HIGH phase closes the period: sample, then advance to the next LOW phase.
        if (state_q == SHIFT && tick) begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            if (bit_q >= SAMPLE_FIRST && bit_q <= SAMPLE_LAST) res_q <= {res_q[DATA_BITS-2:0], sync_q[1]};
            if (bit_q != FRAME_CLKS) begin
              bit_q    <= bit_q + 5'd1;
              din      <= cmd_sr_q[CMD_BITS-1];
              cmd_sr_q <= {cmd_sr_q[CMD_BITS-2:0], 1'b0};
            end
          end
        end
        if (done) cs_n <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ads_spi_master.sv
// ads_spi_master: Avalon-MM register file, flags and irq around one ADS7843 conversion frame engine.
module ads_spi_master
  import ads_spi_pkg::*;
#(
  parameter int CLK_DIV   = 25,
  parameter int DATA_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        ads_dclk,
  output logic        ads_cs_n,
  output logic        ads_din,
  input  logic        ads_dout
);
  logic [CMD_BITS-1:0]  cmd_q;
  logic [DATA_BITS-1:0] data_q, result;
  logic                 done_q, overrun_q, irq_en_q;
  logic                 busy, frame_done, wr, rd, start;
  logic [2:0]           status;
  logic [31:0]          rd_mux;
  assign wr    = chipselect && !write_n;
  assign rd    = chipselect && write_n;
  assign start = wr && address == A_CMD && !busy;
  assign irq   = done_q & irq_en_q;
  always_comb begin
    status              = '0;
    status[ST_BUSY]     = busy;
    status[ST_DONE]     = done_q;
    status[ST_OVERRUN]  = overrun_q;
    rd_mux = address == A_CMD    ? 32'(cmd_q) :
             address == A_DATA   ? 32'(data_q) :
             address == A_STATUS ? 32'(status) : 32'(irq_en_q);
  end
  ads_spi_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS)) u_frame (
    .clk    (clk),
    .rst    (reset),
    .start  (start),
    .cmd    (writedata[CMD_BITS-1:0]),
    .dout   (ads_dout),
    .busy   (busy),
    .done   (frame_done),
    .result (result),
    .dclk   (ads_dclk),
    .cs_n   (ads_cs_n),
    .din    (ads_din)
  );
  // Flag updates: a completing frame beats a same-cycle DATA read; a new overrun beats its clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata  <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      readdata  <= rd_mux;
      if (start) cmd_q <= writedata[CMD_BITS-1:0];
      if (frame_done) data_q <= result;
      done_q    <= frame_done || (done_q && !start && !(rd && address == A_DATA));
      overrun_q <= (wr && address == A_CMD && busy) ||
                   (overrun_q && !(wr && address == A_STATUS && writedata[ST_OVERRUN]));
      if (wr && address == A_CTRL) irq_en_q <= writedata[CTRL_IRQ_EN];
    end
  end
endmodule

// File: tb/tb_ads_spi_master.sv
// tb_ads_spi_master: directed + randomized frames against a converter model and frame-level expectations.
module tb_ads_spi_master;
  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq, ads_dclk, ads_cs_n, ads_din;
  logic        ads_dout = 1'b0;
  int pass_cnt = 0, total = 0;
  int cyc = 0, cs_fall = 0, cs_rise = 0, first_rise = 0, last_fall = 0, rises = 0, falls = 0;
  logic        prev_cs = 1'b1, prev_dclk = 1'b0;
  logic [23:0] din_v = '0;
  logic [11:0] cur_val = '0;
  logic [31:0] r;

  ads_spi_master #(.CLK_DIV(2), .DATA_BITS(12)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq), .ads_dclk(ads_dclk),
    .ads_cs_n(ads_cs_n), .ads_din(ads_din), .ads_dout(ads_dout)
  );

  always #5 clk = ~clk;

  // Pin monitor + converter model: on each DCLK fall, present the result bit owed to the next period.
  always @(negedge clk) begin
    int p;
    p = falls + 2;
    cyc <= cyc + 1;
    prev_cs <= ads_cs_n;
    prev_dclk <= ads_dclk;
    if (prev_cs && !ads_cs_n) begin
      cs_fall <= cyc; rises <= 0; falls <= 0; din_v <= '0;
    end else begin
      if (!prev_dclk && ads_dclk) begin
        rises <= rises + 1;
        if (rises == 0) first_rise <= cyc;
        if (rises < 24) din_v[23 - rises] <= ads_din;
      end
      if (prev_dclk && !ads_dclk) begin
        falls <= falls + 1;
        last_fall <= cyc;
        ads_dout <= (p >= 10 && p <= 21) ? cur_val[11 - (p - 10)] : 1'b0;
      end
    end
    if (!prev_cs && ads_cs_n) cs_rise <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1 address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1 chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1 address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1 chipselect = 1'b0; d = readdata;
  endtask

  // Full frame: command bits MSB-first then zeros, 24 rises, 49*CLK_DIV clks of cs_n low, result in DATA.
  task automatic run_frame(input logic [7:0] cmd, input logic [11:0] val, input logic irq_exp, input int ovr_at);
    logic ok;
    logic [31:0] d;
    cur_val = val;
    wr(2'd0, {24'h0, cmd});
    chk("irq_low_in_frame", {31'h0, irq}, 32'h0);
    if (ovr_at > 0) begin
      repeat (ovr_at - 2) @(posedge clk);
      wr(2'd0, 32'hD3);
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      ok = ads_cs_n === 1'b1;
    end
    chk("frame_end", {31'h0, ok}, 32'h1);
    chk("irq_at_done", {31'h0, irq}, {31'h0, irq_exp});
    @(negedge clk); #1;
    chk("din_pattern", {8'h0, din_v}, {8'h0, cmd, 16'h0});
    chk("dclk_rises", rises, 24);
    chk("cs_low_clks", cs_rise - cs_fall, 98);
    chk("cs_lead", {31'h0, first_rise - cs_fall >= 2}, 32'h1);
    chk("cs_trail", {31'h0, cs_rise - last_fall >= 2}, 32'h1);
    rd(2'd2, d);
    chk("status_done", d, (ovr_at > 0) ? 32'h6 : 32'h2);
    rd(2'd0, d);
    chk("cmd_readback", d, {24'h0, cmd});
    rd(2'd1, d);
    chk("data", d, {20'h0, val});
    chk("irq_after_read", {31'h0, irq}, 32'h0);
    rd(2'd2, d);
    chk("status_cleared", d, (ovr_at > 0) ? 32'h4 : 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic ok;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_cs_n", {31'h0, ads_cs_n}, 32'h1);
    chk("rst_dclk", {31'h0, ads_dclk}, 32'h0);
    chk("rst_din", {31'h0, ads_din}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    rd(2'd2, r);
    chk("rst_status", r, 32'h0);
    run_frame(8'h93, 12'hA5C, 1'b0, 0);
    wr(2'd3, 32'h1);
    rd(2'd3, r);
    chk("ctrl_readback", r, 32'h1);
    run_frame(8'($urandom), 12'($urandom), 1'b1, 0);
    run_frame(8'h93, 12'($urandom), 1'b1, 10);
    wr(2'd2, 32'h4);
    rd(2'd2, r);
    chk("overrun_clear", r, 32'h0);
    wr(2'd3, 32'h0);
    for (int i = 0; i < 3; i++) run_frame(8'($urandom), 12'($urandom), 1'b0, 0);
    cur_val = 12'($urandom);
    wr(2'd0, 32'($urandom_range(255)));
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      ok = falls == 11;
    end
    chk("reach_period12", {31'h0, ok}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("abort_cs_n", {31'h0, ads_cs_n}, 32'h1);
    chk("abort_dclk", {31'h0, ads_dclk}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    rd(2'd1, r);
    chk("abort_data", r, 32'h0);
    rd(2'd2, r);
    chk("abort_status", r, 32'h0);
    run_frame(8'($urandom), 12'($urandom), 1'b0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
